// File: rtl/mem_arbiter.sv
// Unified main-memory port arbiter shared by the I-cache fill FSM, the
// D-cache fill FSM and D-cache write-through stores. A grant covers one
// whole block fill or one store word, and every grant is followed by a
// one-cycle turnaround in which the memory port is idle.
`timescale 1ns/1ps

module mem_arbiter #(
    parameter int WORDS        = 8,
    parameter int STARVE_LIMIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ic_req,
    input  logic [15:0] ic_addr,
    input  logic        dc_req,
    input  logic [15:0] dc_addr,
    input  logic        wr_req,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic        mem_data_valid,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        ic_grant,
    output logic        dc_grant,
    output logic        ic_data_valid,
    output logic        dc_data_valid,
    output logic        ic_fill_done,
    output logic        dc_fill_done,
    output logic        wr_ack,
    output logic        ic_stall,
    output logic        dc_stall
);

    localparam int             BW         = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [BW-1:0]  LAST_BEAT  = BW'(WORDS - 1);
    localparam logic [1:0]     STARVE_CNT = 2'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        IC_FILL,
        DC_FILL,
        DC_WRITE,
        TURN
    } state_t;

    state_t         state;
    state_t         pick;
    logic [BW-1:0]  beat;
    logic [1:0]     streak;
    logic           starved;

    assign starved = ic_req && (streak == STARVE_CNT);

    // Arbitration choice made while idle: a starved I-cache wins, then stores, then D fills, then I fills.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pick = IDLE;
        if (starved)     pick = IC_FILL;
        else if (wr_req) pick = DC_WRITE;
        else if (dc_req) pick = DC_FILL;
        else if (ic_req) pick = IC_FILL;
    end

    // State, beat counter and starvation streak; a fill ends on its last beat or when its owner drops req.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state  <= IDLE;
            beat   <= '0;
            streak <= '0;
        end else begin
            case (state)
                IDLE: state <= pick;
                IC_FILL: begin
                    if (!ic_req) begin
                        state <= TURN;
                        beat  <= '0;
                    end else if (mem_data_valid) begin
                        if (beat == LAST_BEAT) begin
                            state <= TURN;
                            beat  <= '0;
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end
                end
                DC_FILL: begin
                    if (!dc_req) begin
                        state <= TURN;
                        beat  <= '0;
                    end else if (mem_data_valid) begin
                        if (beat == LAST_BEAT) begin
                            state <= TURN;
                            beat  <= '0;
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end
                end
                DC_WRITE: state <= TURN;
                TURN:     state <= IDLE;
                default:  state <= IDLE;
            endcase

            // The streak only counts D-side wins that kept a pending I-cache request waiting.
            if (!ic_req) begin
                streak <= '0;
            end else if (state == IDLE) begin
                if (pick == IC_FILL) begin
                    streak <= '0;
                end else if ((pick == DC_WRITE || pick == DC_FILL) && streak != 2'd3) begin
                    streak <= streak + 2'd1;
                end
            end
        end
    end

    // Port mux and valid steering decoded from the current owner; nothing is forwarded outside a fill.
    always_comb begin
        mem_en        = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = 16'h0000;
        mem_wdata     = 16'h0000;
        ic_grant      = 1'b0;
        dc_grant      = 1'b0;
        ic_data_valid = 1'b0;
        dc_data_valid = 1'b0;
        ic_fill_done  = 1'b0;
        dc_fill_done  = 1'b0;
        wr_ack        = 1'b0;
        case (state)
            IC_FILL: begin
                ic_grant      = 1'b1;
                mem_en        = 1'b1;
                mem_addr      = ic_addr;
                ic_data_valid = mem_data_valid;
                ic_fill_done  = mem_data_valid && ic_req && (beat == LAST_BEAT);
            end
            DC_FILL: begin
                dc_grant      = 1'b1;
                mem_en        = 1'b1;
                mem_addr      = dc_addr;
                dc_data_valid = mem_data_valid;
                dc_fill_done  = mem_data_valid && dc_req && (beat == LAST_BEAT);
            end
            DC_WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
                wr_ack    = 1'b1;
            end
            default: ;
        endcase
    end

    // Stalls for the hazard logic, held low while reset is asserted.
    always_comb begin
        ic_stall = !rst && ic_req && !ic_grant;
        dc_stall = !rst && ((dc_req && !dc_grant) || (wr_req && !wr_ack));
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized run, all compared every cycle against a transaction-level
// model of port ownership.
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int WORDS        = 8;
    localparam int STARVE_LIMIT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req, dc_req, wr_req, mem_data_valid;
    logic [15:0] ic_addr, dc_addr, wr_addr, wr_data;
    logic        mem_en, mem_wr, ic_grant, dc_grant, ic_data_valid, dc_data_valid;
    logic        ic_fill_done, dc_fill_done, wr_ack, ic_stall, dc_stall;
    logic [15:0] mem_addr, mem_wdata;

    always #5 clk = ~clk;

    mem_arbiter #(.WORDS(WORDS), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr),
        .dc_req(dc_req), .dc_addr(dc_addr),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_data_valid(mem_data_valid),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .ic_grant(ic_grant), .dc_grant(dc_grant),
        .ic_data_valid(ic_data_valid), .dc_data_valid(dc_data_valid),
        .ic_fill_done(ic_fill_done), .dc_fill_done(dc_fill_done),
        .wr_ack(wr_ack), .ic_stall(ic_stall), .dc_stall(dc_stall)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    typedef enum int {OWN_NONE, OWN_IC, OWN_DC, OWN_WR} owner_t;

    owner_t m_owner = OWN_NONE;
    bit     m_gap   = 1'b0;   // port is in its post-grant quiet cycle
    int     m_got   = 0;      // beats received in the current fill
    int     m_dwins = 0;      // D-side wins while the I-cache was waiting

    bit ev_ic_done = 1'b0, ev_dc_done = 1'b0, ev_wr_ack = 1'b0;

    logic        e_en, e_wr, e_icg, e_dcg, e_icv, e_dcv, e_icd, e_dcd, e_ack, e_ics, e_dcs;
    logic [15:0] e_addr, e_wdata;

    // Every cycle: derive expected outputs from ownership, compare, then advance the model.
    initial begin
        forever begin
            @(negedge clk);
            e_en = 0; e_wr = 0; e_icg = 0; e_dcg = 0; e_icv = 0; e_dcv = 0;
            e_icd = 0; e_dcd = 0; e_ack = 0; e_ics = 0; e_dcs = 0;
            e_addr = 16'h0; e_wdata = 16'h0;
            if (!rst) begin
                e_en  = (m_owner != OWN_NONE);
                e_icg = (m_owner == OWN_IC);
                e_dcg = (m_owner == OWN_DC);
                e_ack = (m_owner == OWN_WR);
                e_wr  = e_ack;
                if (m_owner == OWN_IC) e_addr = ic_addr;
                if (m_owner == OWN_DC) e_addr = dc_addr;
                if (m_owner == OWN_WR) begin e_addr = wr_addr; e_wdata = wr_data; end
                e_icv = e_icg && mem_data_valid;
                e_dcv = e_dcg && mem_data_valid;
                e_icd = e_icv && ic_req && (m_got == WORDS - 1);
                e_dcd = e_dcv && dc_req && (m_got == WORDS - 1);
                e_ics = ic_req && !e_icg;
                e_dcs = (dc_req && !e_dcg) || (wr_req && !e_ack);
            end
            check1 ("mem_en", mem_en, e_en);
            check1 ("mem_wr", mem_wr, e_wr);
            check16("mem_addr", mem_addr, e_addr);
            check16("mem_wdata", mem_wdata, e_wdata);
            check1 ("ic_grant", ic_grant, e_icg);
            check1 ("dc_grant", dc_grant, e_dcg);
            check1 ("ic_data_valid", ic_data_valid, e_icv);
            check1 ("dc_data_valid", dc_data_valid, e_dcv);
            check1 ("ic_fill_done", ic_fill_done, e_icd);
            check1 ("dc_fill_done", dc_fill_done, e_dcd);
            check1 ("wr_ack", wr_ack, e_ack);
            check1 ("ic_stall", ic_stall, e_ics);
            check1 ("dc_stall", dc_stall, e_dcs);
            if (e_icd) ev_ic_done = 1'b1;
            if (e_dcd) ev_dc_done = 1'b1;
            if (e_ack) ev_wr_ack  = 1'b1;

            if (rst) begin
                m_owner = OWN_NONE; m_gap = 0; m_got = 0; m_dwins = 0;
            end else if (m_owner == OWN_WR) begin
                m_owner = OWN_NONE; m_gap = 1;
            end else if (m_owner == OWN_IC || m_owner == OWN_DC) begin
                if (!((m_owner == OWN_IC) ? ic_req : dc_req)) begin
                    m_owner = OWN_NONE; m_gap = 1; m_got = 0;
                end else if (mem_data_valid) begin
                    m_got++;
                    if (m_got == WORDS) begin m_owner = OWN_NONE; m_gap = 1; m_got = 0; end
                end
            end else if (m_gap) begin
                m_gap = 0;
            end else begin
                if (ic_req && m_dwins >= STARVE_LIMIT) m_owner = OWN_IC;
                else if (wr_req)                      m_owner = OWN_WR;
                else if (dc_req)                      m_owner = OWN_DC;
                else if (ic_req)                      m_owner = OWN_IC;
                if (m_owner == OWN_IC) m_dwins = 0;
                else if (m_owner != OWN_NONE && ic_req && m_dwins < 3) m_dwins++;
            end
            if (!rst && !ic_req) m_dwins = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ic_req = 0; dc_req = 0; wr_req = 0; mem_data_valid = 0;
        repeat (n) tick();
    endtask

    // Deliver one full block of valids to the current owner, pinning the done pulse.
    task automatic run_fill(input bit is_ic);
        for (int b = 0; b < WORDS; b++) begin
            mem_data_valid = 1'b1;
            #1;
            if (is_ic) begin
                check1("fill ic_data_valid", ic_data_valid, 1'b1);
                check1("fill ic_fill_done", ic_fill_done, b == WORDS - 1);
                check1("fill dc_data_valid", dc_data_valid, 1'b0);
            end else begin
                check1("fill dc_data_valid", dc_data_valid, 1'b1);
                check1("fill dc_fill_done", dc_fill_done, b == WORDS - 1);
                check1("fill ic_data_valid", ic_data_valid, 1'b0);
            end
            tick();
        end
        mem_data_valid = 1'b0;
    endtask

    initial begin
        rst = 1; ic_req = 0; dc_req = 0; wr_req = 0; mem_data_valid = 0;
        ic_addr = 0; dc_addr = 0; wr_addr = 0; wr_data = 0;
        repeat (3) tick();
        check1("reset mem_en", mem_en, 1'b0);
        check1("reset ic_grant", ic_grant, 1'b0);

        // Single I-cache fill from reset.
        rst = 0; ic_req = 1; ic_addr = 16'h1230;
        tick();
        check1 ("t1 ic_grant", ic_grant, 1'b1);
        check16("t1 mem_addr", mem_addr, 16'h1230);
        run_fill(1'b1);
        ic_req = 0; mem_data_valid = 1;
        #1;
        check1("t1 turn mem_en", mem_en, 1'b0);
        check1("t1 turn stray valid", ic_data_valid, 1'b0);
        tick();
        mem_data_valid = 1;
        #1;
        check1("t1 idle stray ic", ic_data_valid, 1'b0);
        check1("t1 idle stray dc", dc_data_valid, 1'b0);
        idle(2);

        // All three requesters at once: store, then D fill, then I fill.
        wr_req = 1; wr_addr = 16'hA5A0; wr_data = 16'h5A5A;
        dc_req = 1; dc_addr = 16'h2000; ic_req = 1; ic_addr = 16'h3000;
        tick();
        check1 ("t2 wr_ack", wr_ack, 1'b1);
        check1 ("t2 mem_wr", mem_wr, 1'b1);
        check16("t2 mem_addr", mem_addr, 16'hA5A0);
        check16("t2 mem_wdata", mem_wdata, 16'h5A5A);
        check1 ("t2 ic_stall", ic_stall, 1'b1);
        tick();
        wr_req = 0;
        tick();
        tick();
        check1 ("t2 dc_grant", dc_grant, 1'b1);
        check16("t2 dc mem_addr", mem_addr, 16'h2000);
        run_fill(1'b0);
        dc_req = 0;
        tick();
        tick();
        check1("t2 ic_grant", ic_grant, 1'b1);
        check1("t2 ic_stall clear", ic_stall, 1'b0);
        run_fill(1'b1);
        idle(3);

        // Starvation: stores keep coming while the I-cache waits.
        ic_req = 1; ic_addr = 16'h4440; wr_req = 1; wr_addr = 16'h0F00; wr_data = 16'h1234;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check1("t3 wr_ack", wr_ack, e == 1 || e == 4);
            check1("t3 ic_grant", ic_grant, e == 7);
        end
        check1("t3 dc_stall", dc_stall, 1'b1);
        wr_req = 0;
        run_fill(1'b1);
        wr_req = 1;
        tick();
        tick();
        check1("t3 streak cleared wr_ack", wr_ack, 1'b1);
        check1("t3 streak cleared ic_grant", ic_grant, 1'b0);
        idle(3);

        // Reset in the middle of a D fill.
        dc_req = 1; dc_addr = 16'h7700;
        tick();
        repeat (5) begin mem_data_valid = 1; tick(); end
        rst = 1; mem_data_valid = 1;
        #1;
        check1("t4 rst mem_en", mem_en, 1'b0);
        check1("t4 rst dc_grant", dc_grant, 1'b0);
        check1("t4 rst dc_data_valid", dc_data_valid, 1'b0);
        check1("t4 rst dc_stall", dc_stall, 1'b0);
        tick();
        rst = 0;
        #1;
        check1("t4 late valid dropped", dc_data_valid, 1'b0);
        tick();
        mem_data_valid = 0;
        check1("t4 dc_grant again", dc_grant, 1'b1);
        run_fill(1'b0);
        idle(3);

        // Abort an I fill after three beats, then a clean D fill.
        ic_req = 1; ic_addr = 16'h5550;
        tick();
        repeat (3) begin mem_data_valid = 1; tick(); end
        ic_req = 0; mem_data_valid = 0;
        #1;
        check1("t5 abort no done", ic_fill_done, 1'b0);
        tick();
        check1("t5 turn mem_en", mem_en, 1'b0);
        dc_req = 1; dc_addr = 16'h6660;
        tick();
        tick();
        check1("t5 dc_grant", dc_grant, 1'b1);
        run_fill(1'b0);
        idle(3);

        // Randomized traffic with occasional aborts and resets.
        ev_ic_done = 0; ev_dc_done = 0; ev_wr_ack = 0;
        for (int c = 0; c < 3000; c++) begin
            mem_data_valid = ($urandom_range(0, 2) == 0);
            ic_addr = 16'($urandom);
            dc_addr = 16'($urandom);
            if (ic_req) begin
                if (ev_ic_done || $urandom_range(0, 99) == 0) ic_req = 0;
            end else if ($urandom_range(0, 5) == 0) ic_req = 1;
            if (dc_req) begin
                if (ev_dc_done || $urandom_range(0, 99) == 0) dc_req = 0;
            end else if ($urandom_range(0, 5) == 0) dc_req = 1;
            if (wr_req) begin
                if (ev_wr_ack) begin
                    wr_req  = ($urandom_range(0, 1) == 0);
                    wr_addr = 16'($urandom);
                    wr_data = 16'($urandom);
                end
            end else if ($urandom_range(0, 4) == 0) begin
                wr_req  = 1;
                wr_addr = 16'($urandom);
                wr_data = 16'($urandom);
            end
            rst = ($urandom_range(0, 399) == 0);
            ev_ic_done = 0; ev_dc_done = 0; ev_wr_ack = 0;
            tick();
        end
        rst = 0;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
